// File: rtl/shuma_scan.sv
// shuma_scan: multiplexed 7-segment driver for common-cathode displays.
// Holds a DIGITS-wide BCD shadow register, scans one digit per SCAN_DIV
// cycles onto a shared segment bus, and drives active-low digit selects.
// Each slot opens with GUARD cycles of all-off selects to hide ghosting.
// Supports global blanking (bi) and frame-based blinking (blink).
// Optional build macro SHUMA_HEX_EN: codes 10..15 show A,b,C,d,E,F
// instead of blanking.
module shuma_scan #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int GUARD        = 1,
    parameter int BLINK_FRAMES = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  bi,
    input  logic                  blink,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GUARD_C    = PW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [4*DIGITS-1:0] r_data;
    logic [DIGITS-1:0]   r_dp_sh;
    logic [PW-1:0]       r_presc;
    logic [IW-1:0]       r_idx;
    logic [FW-1:0]       r_frame;
    logic                r_phase;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_dig_sel;

    logic                w_tick;
    logic                w_wrap;
    logic [PW-1:0]       w_presc_nx;
    logic [IW-1:0]       w_idx_nx;
    logic [FW-1:0]       w_frame_nx;
    logic                w_phase_nx;
    logic [4*DIGITS-1:0] w_data_nx;
    logic [DIGITS-1:0]   w_dp_sh_nx;
    logic [3:0]          w_bcd;
    logic                w_dp_bit;
    logic [DIGITS-1:0]   w_sel_n;
    logic                w_guard;
    logic                w_blank;

    // BCD to {a,b,c,d,e,f,g}; unused codes are always a defined value.
    function automatic logic [6:0] f_decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
`ifdef SHUMA_HEX_EN
            4'd10:   s = 7'b1110111;
            4'd11:   s = 7'b0011111;
            4'd12:   s = 7'b1001110;
            4'd13:   s = 7'b0111101;
            4'd14:   s = 7'b1001111;
            4'd15:   s = 7'b1000111;
`endif
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Scan timing: prescaler tick, digit index advance, frame wrap detect.
    always_comb begin
        w_tick     = (r_presc == PRESC_LAST);
        w_wrap     = w_tick && (r_idx == IDX_LAST);
        w_presc_nx = w_tick ? '0 : r_presc + 1'b1;
        w_idx_nx   = r_idx;
        if (w_tick) begin
            w_idx_nx = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
    end

    // Blink: count frame wraps; phase flips each BLINK_FRAMES frames, held at 0 when disabled.
    always_comb begin
        w_frame_nx = r_frame;
        w_phase_nx = r_phase;
        if (!blink) begin
            w_frame_nx = '0;
            w_phase_nx = 1'b0;
        end else if (w_wrap) begin
            if (r_frame == FRAME_LAST) begin
                w_frame_nx = '0;
                w_phase_nx = ~r_phase;
            end else begin
                w_frame_nx = r_frame + 1'b1;
            end
        end
    end

    // Next-state shadow and the digit it selects, so loads show on the same edge.
    always_comb begin
        w_data_nx  = load ? data  : r_data;
        w_dp_sh_nx = load ? dp_in : r_dp_sh;
        w_bcd      = 4'd0;
        w_dp_bit   = 1'b0;
        w_sel_n    = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idx_nx == IW'(i)) begin
                w_bcd      = w_data_nx[4*i +: 4];
                w_dp_bit   = w_dp_sh_nx[i];
                w_sel_n[i] = 1'b0;
            end
        end
        w_guard = (w_presc_nx < GUARD_C);
        w_blank = bi || w_phase_nx;
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_dp_sh   <= '0;
            r_presc   <= '0;
            r_idx     <= '0;
            r_frame   <= '0;
            r_phase   <= 1'b0;
            r_seg     <= 7'b0000000;
            r_dp      <= 1'b0;
            r_dig_sel <= '1;
        end else begin
            r_data    <= w_data_nx;
            r_dp_sh   <= w_dp_sh_nx;
            r_presc   <= w_presc_nx;
            r_idx     <= w_idx_nx;
            r_frame   <= w_frame_nx;
            r_phase   <= w_phase_nx;
            r_seg     <= w_blank ? 7'b0000000 : f_decode(w_bcd);
            r_dp      <= !w_blank && w_dp_bit;
            r_dig_sel <= w_guard ? '1 : w_sel_n;
        end
    end

    assign seg     = r_seg;
    assign dp      = r_dp;
    assign dig_sel = r_dig_sel;

endmodule

// File: tb/tb_shuma_scan.sv
// Directed bench for shuma_scan with DIGITS=4, SCAN_DIV=4, GUARD=1,
// BLINK_FRAMES=2. Edge count e restarts at 0 on reset release, so after
// edge e the slot is (e/4)%4 and the prescaler is e%4.
module tb_shuma_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic        load;
    logic        bi;
    logic        blink;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig_sel;

    int n_checks = 0;
    int n_errors = 0;
    int e = 0;

    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S1 = 7'b0110000;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011;
    localparam logic [6:0] S5 = 7'b1011011;
    localparam logic [6:0] S9 = 7'b1111011;
`ifdef SHUMA_HEX_EN
    localparam logic [6:0] SC = 7'b1001110;
`else
    localparam logic [6:0] SC = 7'b0000000;
`endif

    // Expected lit pattern per slot for the currently loaded shadow.
    logic [6:0] lit_tab [4];

    shuma_scan #(
        .DIGITS(4), .SCAN_DIV(4), .GUARD(1), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .load(load),
        .bi(bi), .blink(blink), .seg(seg), .dp(dp), .dig_sel(dig_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (e=%0d): got %0h expected %0h", tag, e, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    function automatic logic [3:0] exp_sel(input int k);
        logic [3:0] one;
        one = 4'b0001;
        if ((k % 4) == 0) return 4'b1111;
        return ~(one << ((k / 4) % 4));
    endfunction

    // Slot check: lit selects whether the digit should be visible.
    task automatic check_slot(input string tag, input logic lit);
        int ix;
        ix = (e / 4) % 4;
        check({tag, "_seg"}, 32'(seg), lit ? 32'(lit_tab[ix]) : 32'd0);
        check({tag, "_dp"}, 32'(dp), (lit && ix == 2) ? 32'd1 : 32'd0);
        check({tag, "_sel"}, 32'(dig_sel), 32'(exp_sel(e)));
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; bi = 1'b0; blink = 1'b0;
        data = 16'h0; dp_in = 4'h0;
        #1 rst = 1'b1;
        #2;
        check("rst_seg", 32'(seg), 32'd0);
        check("rst_dp", 32'(dp), 32'd0);
        check("rst_sel", 32'(dig_sel), 32'hF);
        step(); step();
        check("rst_hold_sel", 32'(dig_sel), 32'hF);

        // Release and load 4321 with dp on digit 2 at the first edge.
        rst = 1'b0; e = 0;
        load = 1'b1; data = 16'h4321; dp_in = 4'b0100;
        lit_tab = '{S1, S2, S3, S4};
        step();
        load = 1'b0;
        check_slot("scan", 1'b1);
        while (e < 16) begin step(); check_slot("scan", 1'b1); end

        // Non-BCD nibble in digit 2.
        load = 1'b1; data = 16'h4C21;
        step();
        load = 1'b0;
        lit_tab[2] = SC;
        check_slot("code_c", 1'b1);
        while (e < 28) begin step(); check_slot("code_c", 1'b1); end

        // Global blank: segments off, scanning continues.
        bi = 1'b1;
        while (e < 44) begin step(); check_slot("bi", 1'b0); end
        bi = 1'b0;
        while (e < 48) begin step(); check_slot("bi_off", 1'b1); end

        // Blink: off over edges 80..100 (dropped at 100), re-enabled at 112
        // from phase 0 so it next goes dark at edge 144, then dropped again.
        blink = 1'b1;
        while (e < 145) begin
            step();
            check_slot("blink", !((e >= 80 && e <= 100) || e == 144));
            if (e == 100) blink = 1'b0;
            if (e == 112) blink = 1'b1;
            if (e == 144) blink = 1'b0;
        end

        // Load coincident with the tick into slot 1: 5 then 9 on the tick edge.
        load = 1'b1; data = 16'h4C51;
        step();
        load = 1'b0;
        lit_tab[1] = S5;
        check_slot("pre_tick", 1'b1);
        step();
        check_slot("pre_tick", 1'b1);
        load = 1'b1; data = 16'h4C91;
        step();
        load = 1'b0;
        lit_tab[1] = S9;
        check_slot("tick_load", 1'b1);
        while (e < 150) begin step(); check_slot("tick_load", 1'b1); end

        // Asynchronous reset mid-slot.
        #3 rst = 1'b1;
        #1;
        check("arst_seg", 32'(seg), 32'd0);
        check("arst_dp", 32'(dp), 32'd0);
        check("arst_sel", 32'(dig_sel), 32'hF);
        step(); step();
        check("arst_hold_seg", 32'(seg), 32'd0);
        rst = 1'b0; e = 0;
        step();
        check("rel_seg", 32'(seg), 32'(S0));
        check("rel_dp", 32'(dp), 32'd0);
        check("rel_sel", 32'(dig_sel), 32'hE);
        step(); step(); step();
        check("rel_guard_sel", 32'(dig_sel), 32'hF);
        check("rel_guard_seg", 32'(seg), 32'(S0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
